// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the datapath bus, load enables, ALU and memory.
// Define CTRL_PERF_CNT_EN to add the retired-instruction counter output.
module control_sequencer #(
  parameter logic [5:0] ALU_ADD = 6'd3,
  parameter logic [5:0] ALU_SUB = 6'd4,
  parameter logic [5:0] ALU_AND = 6'd5,
  parameter logic [5:0] ALU_OR  = 6'd6,
  parameter logic [5:0] ALU_MUL = 6'd15,
  parameter logic [5:0] ALU_DIV = 6'd16,
  parameter logic [5:0] ALU_INC = 6'd31
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_data_out,
  input  logic        mem_ready,
  output logic [31:0] out_sel,
  output logic [31:0] in_en,
  output logic [5:0]  ALU_Sel,
  output logic        read,
  output logic        mem_write,
  output logic        halted,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0] retired,
`endif
  output logic        illegal
);

  localparam logic [31:0] SelHi   = 32'd1 << 16;
  localparam logic [31:0] SelLo   = 32'd1 << 17;
  localparam logic [31:0] SelZhi  = 32'd1 << 18;
  localparam logic [31:0] SelZlo  = 32'd1 << 19;
  localparam logic [31:0] SelPc   = 32'd1 << 20;
  localparam logic [31:0] SelIr   = 32'd1 << 21;
  localparam logic [31:0] SelMdr  = 32'd1 << 22;
  localparam logic [31:0] SelMar  = 32'd1 << 23;
  localparam logic [31:0] SelY    = 32'd1 << 24;
  localparam logic [31:0] SelC    = 32'd1 << 25;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  typedef enum logic [3:0] {
    StT0, StT1, StT1Wait, StT2, StT3, StT4, StT5, StT6, StT7, StHalted
  } state_t;

  state_t      r_state, w_next;
  logic [4:0]  w_op;
  logic [31:0] w_sel_ra, w_sel_rb, w_sel_rc;
  logic        w_is_alu, w_is_muldiv, w_is_ld, w_is_st, w_is_nop, w_is_halt, w_is_exec;
  logic [5:0]  w_alu_op;
  logic        w_retire;
  logic        w_unused;

  // IR already holds the new instruction from T3 onward, so decode reads it directly.
  assign w_op     = IR_data_out[31:27];
  assign w_sel_ra = 32'd1 << IR_data_out[26:23];
  assign w_sel_rb = 32'd1 << IR_data_out[22:19];
  assign w_sel_rc = 32'd1 << IR_data_out[18:15];
  assign w_unused = ^{IR_data_out[14:0], w_retire};

  always_comb begin
    w_is_alu    = 1'b0;
    w_is_muldiv = 1'b0;
    w_alu_op    = ALU_ADD;
    case (w_op)
      OpAdd: begin w_is_alu = 1'b1; w_alu_op = ALU_ADD; end
      OpSub: begin w_is_alu = 1'b1; w_alu_op = ALU_SUB; end
      OpAnd: begin w_is_alu = 1'b1; w_alu_op = ALU_AND; end
      OpOr:  begin w_is_alu = 1'b1; w_alu_op = ALU_OR;  end
      OpMul: begin w_is_muldiv = 1'b1; w_alu_op = ALU_MUL; end
      OpDiv: begin w_is_muldiv = 1'b1; w_alu_op = ALU_DIV; end
      default: ;
    endcase
  end

  assign w_is_ld   = (w_op == OpLd);
  assign w_is_st   = (w_op == OpSt);
  assign w_is_nop  = (w_op == OpNop);
  assign w_is_halt = (w_op == OpHalt);
  assign w_is_exec = w_is_alu | w_is_muldiv | w_is_ld | w_is_st;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= StT0;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    out_sel   = '0;
    in_en     = '0;
    ALU_Sel   = '0;
    read      = 1'b0;
    mem_write = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    w_retire  = 1'b0;
    unique case (r_state)
      StT0: begin
        out_sel = SelPc;
        in_en   = SelMar | SelZlo;
        ALU_Sel = ALU_INC;
        w_next  = StT1;
      end
      StT1, StT1Wait: begin
        out_sel = SelZlo;
        read    = 1'b1;
        if (r_state == StT1) in_en = SelPc;
        if (mem_ready) begin
          in_en  = in_en | SelMdr;
          w_next = StT2;
        end else begin
          w_next = StT1Wait;
        end
      end
      StT2: begin
        out_sel = SelMdr;
        in_en   = SelIr;
        w_next  = StT3;
      end
      StT3: begin
        if (w_is_halt) begin
          w_next = StHalted;
        end else if (w_is_exec) begin
          out_sel = w_sel_rb;
          in_en   = SelY;
          w_next  = StT4;
        end else begin
          illegal  = ~w_is_nop;
          w_retire = 1'b1;
          w_next   = StT0;
        end
      end
      StT4: begin
        if (w_is_ld || w_is_st) begin
          out_sel = SelC;
          ALU_Sel = ALU_ADD;
          in_en   = SelZlo;
        end else begin
          out_sel = w_sel_rc;
          ALU_Sel = w_alu_op;
          in_en   = SelZhi | SelZlo;
        end
        w_next = StT5;
      end
      StT5: begin
        out_sel = SelZlo;
        if (w_is_alu) begin
          in_en    = w_sel_ra;
          w_retire = 1'b1;
          w_next   = StT0;
        end else begin
          in_en  = w_is_muldiv ? SelLo : SelMar;
          w_next = StT6;
        end
      end
      StT6: begin
        if (w_is_muldiv) begin
          out_sel  = SelZhi;
          in_en    = SelHi;
          w_retire = 1'b1;
          w_next   = StT0;
        end else if (w_is_ld) begin
          read = 1'b1;
          if (mem_ready) begin
            in_en  = SelMdr;
            w_next = StT7;
          end
        end else begin
          out_sel = w_sel_ra;
          in_en   = SelMdr;
          w_next  = StT7;
        end
      end
      StT7: begin
        if (w_is_ld) begin
          out_sel  = SelMdr;
          in_en    = w_sel_ra;
          w_retire = 1'b1;
          w_next   = StT0;
        end else begin
          mem_write = 1'b1;
          if (mem_ready) begin
            w_retire = 1'b1;
            w_next   = StT0;
          end
        end
      end
      StHalted: halted = 1'b1;
      default:  w_next = StT0;
    endcase
    // Strobes must fall the moment clr rises, not on the next edge.
    if (clr) begin
      out_sel   = '0;
      in_en     = '0;
      ALU_Sel   = '0;
      read      = 1'b0;
      mem_write = 1'b0;
      halted    = 1'b0;
      illegal   = 1'b0;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_retired;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)           r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + 32'd1;
  end

  assign retired = r_retired;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a per-instruction cycle plan is built from the
// instruction semantics, driven cycle by cycle, and checked by an independent negedge monitor.
module tb_control_sequencer;

  localparam int HI = 16, LO = 17, ZHI = 18, ZLO = 19, PC = 20, IR = 21, MDR = 22, MAR = 23;
  localparam int Y = 24, C = 25;

  typedef struct packed {
    logic [31:0] osel;
    logic [31:0] ien;
    logic [5:0]  alu;
    logic        rd;
    logic        wr;
    logic        hlt;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  typedef struct packed {
    exp_t e;
    logic rdy;
  } step_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        mem_ready;
  logic [31:0] ir_q = '0;
  logic [31:0] ir_pending;
  logic [31:0] out_sel, in_en;
  logic [5:0]  ALU_Sel;
  logic        read, mem_write, halted, illegal;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired;
`endif

  exp_t        exp_q[$];
  step_t       plan_q[$];
  exp_t        m_e;
  logic [31:0] model_ret;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  control_sequencer dut (
    .clk         (clk),
    .clr         (clr),
    .IR_data_out (ir_q),
    .mem_ready   (mem_ready),
    .out_sel     (out_sel),
    .in_en       (in_en),
    .ALU_Sel     (ALU_Sel),
    .read        (read),
    .mem_write   (mem_write),
    .halted      (halted),
`ifdef CTRL_PERF_CNT_EN
    .retired     (retired),
`endif
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Stand-in for the datapath IR register.
  always @(posedge clk) if (in_en[IR]) ir_q <= ir_pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      check("out_sel", out_sel, m_e.osel);
      check("in_en", in_en, m_e.ien);
      check("alu_sel", {26'd0, ALU_Sel}, {26'd0, m_e.alu});
      check("strobes", {28'd0, read, mem_write, halted, illegal},
            {28'd0, m_e.rd, m_e.wr, m_e.hlt, m_e.ill});
`ifdef CTRL_PERF_CNT_EN
      check("retired", retired, m_e.ret);
`endif
    end
  end

  function automatic logic [31:0] sel(input int n);
    return (n < 0) ? 32'd0 : (32'd1 << n);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [3:0] rc,
                                      input logic [14:0] imm);
    return {op, ra, rb, rc, imm};
  endfunction

  function automatic logic [5:0] alu_code(input logic [4:0] op);
    case (op)
      5'd3:    return 6'd3;
      5'd4:    return 6'd4;
      5'd5:    return 6'd5;
      5'd6:    return 6'd6;
      5'd15:   return 6'd15;
      default: return 6'd16;
    endcase
  endfunction

  task automatic add_step(input int src, input logic [31:0] ld, input logic [5:0] alu,
                          input logic rd, input logic wr, input logic rdy,
                          input logic ill, input logic hlt);
    step_t s;
    s.e.osel = sel(src);
    s.e.ien  = ld;
    s.e.alu  = alu;
    s.e.rd   = rd;
    s.e.wr   = wr;
    s.e.hlt  = hlt;
    s.e.ill  = ill;
    s.e.ret  = model_ret;
    s.rdy    = rdy;
    plan_q.push_back(s);
  endtask

  // wf / we: cycles memory stays not-ready during fetch / execute access.
  task automatic plan_instr(input logic [31:0] ir, input int wf, input int we);
    logic [4:0] op = ir[31:27];
    int ra = int'(ir[26:23]);
    int rb = int'(ir[22:19]);
    int rc = int'(ir[18:15]);
    add_step(PC, sel(MAR) | sel(ZLO), 6'd31, 1'b0, 1'b0, rnd_bit(), 1'b0, 1'b0);
    for (int i = 0; i <= wf; i++)
      add_step(ZLO, ((i == 0) ? sel(PC) : 32'd0) | ((i == wf) ? sel(MDR) : 32'd0), 6'd0,
               1'b1, 1'b0, 1'(i == wf), 1'b0, 1'b0);
    add_step(MDR, sel(IR), 6'd0, 1'b0, 1'b0, rnd_bit(), 1'b0, 1'b0);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd15, 5'd16: begin
        add_step(rb, sel(Y), 6'd0, 1'b0, 1'b0, rnd_bit(), 1'b0, 1'b0);
        add_step(rc, sel(ZHI) | sel(ZLO), alu_code(op), 1'b0, 1'b0, rnd_bit(), 1'b0, 1'b0);
        if (op < 5'd15) begin
          add_step(ZLO, sel(ra), 6'd0, 1'b0, 1'b0, rnd_bit(), 1'b0, 1'b0);
        end else begin
          add_step(ZLO, sel(LO), 6'd0, 1'b0, 1'b0, rnd_bit(), 1'b0, 1'b0);
          add_step(ZHI, sel(HI), 6'd0, 1'b0, 1'b0, rnd_bit(), 1'b0, 1'b0);
        end
      end
      5'd0, 5'd2: begin
        add_step(rb, sel(Y), 6'd0, 1'b0, 1'b0, rnd_bit(), 1'b0, 1'b0);
        add_step(C, sel(ZLO), 6'd3, 1'b0, 1'b0, rnd_bit(), 1'b0, 1'b0);
        add_step(ZLO, sel(MAR), 6'd0, 1'b0, 1'b0, rnd_bit(), 1'b0, 1'b0);
        if (op == 5'd0) begin
          for (int i = 0; i <= we; i++)
            add_step(-1, (i == we) ? sel(MDR) : 32'd0, 6'd0, 1'b1, 1'b0, 1'(i == we),
                     1'b0, 1'b0);
          add_step(MDR, sel(ra), 6'd0, 1'b0, 1'b0, rnd_bit(), 1'b0, 1'b0);
        end else begin
          add_step(ra, sel(MDR), 6'd0, 1'b0, 1'b0, rnd_bit(), 1'b0, 1'b0);
          for (int i = 0; i <= we; i++)
            add_step(-1, 32'd0, 6'd0, 1'b0, 1'b1, 1'(i == we), 1'b0, 1'b0);
        end
      end
      5'd26, 5'd27: add_step(-1, 32'd0, 6'd0, 1'b0, 1'b0, rnd_bit(), 1'b0, 1'b0);
      default:      add_step(-1, 32'd0, 6'd0, 1'b0, 1'b0, rnd_bit(), 1'b1, 1'b0);
    endcase
    if (op != 5'd27) model_ret++;
  endtask

  task automatic run_plan(input int limit);
    step_t s;
    for (int n = 0; n < limit && plan_q.size() > 0; n++) begin
      s = plan_q.pop_front();
      exp_q.push_back(s.e);
      mem_ready = s.rdy;
      @(posedge clk);
      #1;
    end
    plan_q.delete();
  endtask

  task automatic issue(input logic [31:0] ir, input int wf, input int we);
    ir_pending = ir;
    plan_instr(ir, wf, we);
    run_plan(1000);
  endtask

  task automatic quiet_cycle(input logic hlt);
    add_step(-1, 32'd0, 6'd0, 1'b0, 1'b0, rnd_bit(), 1'b0, hlt);
    run_plan(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] op;
    int         pick;
    clr        = 1'b1;
    mem_ready  = 1'b0;
    ir_pending = '0;
    model_ret  = '0;
    @(posedge clk);
    #1;
    repeat (2) quiet_cycle(1'b0);
    clr = 1'b0;

    issue(32'h18918000, 0, 0);                       // ADD R1,R2,R3
    issue(enc(5'd26, 4'd0, 4'd0, 4'd0, 15'd0), 3, 0); // NOP with 3 fetch wait states
    issue(32'h02100010, 0, 2);                       // LD R4,0x10(R2)
    issue(enc(5'd2, 4'd7, 4'd1, 4'd0, 15'd5), 1, 2);  // ST R7,5(R1)
    issue(enc(5'd15, 4'd0, 4'd5, 4'd6, 15'd0), 0, 0); // MUL R5,R6
    issue(enc(5'd16, 4'd0, 4'd7, 4'd8, 15'd0), 2, 0); // DIV R7,R8
    issue(enc(5'd31, 4'd3, 4'd3, 4'd3, 15'd0), 0, 0); // unknown opcode
    issue(enc(5'd4, 4'd0, 4'd15, 4'd14, 15'd0), 0, 0); // SUB into R0

    for (int k = 0; k < 25; k++) begin
      pick = int'($urandom_range(0, 10));
      case (pick)
        0:       op = 5'd0;
        1:       op = 5'd2;
        2:       op = 5'd3;
        3:       op = 5'd4;
        4:       op = 5'd5;
        5:       op = 5'd6;
        6:       op = 5'd15;
        7:       op = 5'd16;
        8:       op = 5'd26;
        9:       op = 5'd1;
        default: op = 5'd7;
      endcase
      issue(enc(op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Abort an LD while it waits on memory in T6.
    ir_pending = enc(5'd0, 4'd9, 4'd3, 4'd0, 15'd7);
    plan_instr(ir_pending, 0, 5);
    run_plan(8);
    clr       = 1'b1;
    model_ret = '0;
    repeat (2) quiet_cycle(1'b0);
    clr = 1'b0;
    issue(enc(5'd5, 4'd2, 4'd11, 4'd12, 15'd0), 0, 0);

    issue(enc(5'd27, 4'd0, 4'd0, 4'd0, 15'd0), 1, 0); // HALT
    repeat (20) quiet_cycle(1'b1);
    clr       = 1'b1;
    model_ret = '0;
    quiet_cycle(1'b0);
    clr = 1'b0;
    issue(enc(5'd26, 4'd0, 4'd0, 4'd0, 15'd0), 0, 0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
